bus_result_monitor: RTL and testbench

- Passive checker on the CPU external memory bus, downstream of the CPU core and in parallel with the memory block.
- Snoops writes to one result address, counts run cycles and grades the program run as PASS, FAIL or TIMEOUT.
- Replaces fixed-delay RAM peeks in regression benches, and can also be synthesised for FPGA bring-up.

---
 rtl/mon_pkg.sv | 25 ++
 rtl/halt_detector.sv | 48 ++++
 rtl/bus_result_monitor.sv | 146 ++++++++++++++
 tb/tb_bus_result_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared state encoding, default constants and saturating counters
package mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_e;

  localparam logic [15:0] DEF_RESULT_ADDR    = 16'h0042;
  localparam logic [7:0]  DEF_EXPECT         = 8'hCF;
  localparam logic [15:0] DEF_TIMEOUT_CYCLES = 16'd64;
  localparam logic [3:0]  DEF_HALT_COUNT     = 4'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/halt_detector.sv
// rtl/halt_detector.sv - flags a run of HALT_COUNT opcode fetches from one PC
// Combinational halt pulse fires in the fetch cycle that completes the run.
module halt_detector #(
  parameter logic [3:0] HALT_COUNT = 4'd3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        sync_i,
  input  logic [15:0] address_i,
  output logic        halt_o
);

  logic [15:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    cnt_d      = cnt_q;
    if (enable_i && sync_i) begin
      pc_d       = address_i;
      pc_valid_d = 1'b1;
      // first fetch after reset has no predecessor, so it starts a new run
      if (pc_valid_q && (address_i == pc_q)) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end
  end

  assign halt_o = enable_i && sync_i && (cnt_d >= HALT_COUNT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= 16'h0000;
      pc_valid_q <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_result_monitor.sv
// rtl/bus_result_monitor.sv - snoops the CPU bus and grades a run as PASS/FAIL/TIMEOUT
// Optional halt-on-self-loop detection is enabled with `define MON_HALT_EN.
module bus_result_monitor
  import mon_pkg::*;
#(
  parameter logic [15:0] RESULT_ADDR    = DEF_RESULT_ADDR,
  parameter logic [7:0]  EXPECT         = DEF_EXPECT,
  parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [3:0]  HALT_COUNT     = DEF_HALT_COUNT
) (
  input  logic        ph2,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_out,
  input  logic        memwrite,
  input  logic        sync,
  output logic [2:0]  state,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic [15:0] cycles,
  output logic [7:0]  wr_count
`ifdef MON_HALT_EN
  ,
  output logic        halted
`endif
);

  // A zero-length window would never end, so it is widened to one cycle.
  localparam logic [15:0] WINDOW  = (TIMEOUT_CYCLES == 16'd0) ? 16'd1 : TIMEOUT_CYCLES;
  localparam logic [15:0] END_CYC = WINDOW - 16'd1;

  mon_state_e  state_q, state_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [7:0]  result_q, result_d;
  logic        valid_q, valid_d;
  logic [15:0] cycles_q, cycles_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic        halted_q, halted_d;
  logic        halt_fire;
  logic        end_cond;
  logic        in_run;

  assign in_run = (state_q == ST_RUN);

`ifdef MON_HALT_EN
  halt_detector #(
    .HALT_COUNT(HALT_COUNT)
  ) u_halt (
    .clk_i    (ph2),
    .reset_i  (reset),
    .enable_i (in_run),
    .sync_i   (sync),
    .address_i(address),
    .halt_o   (halt_fire)
  );
  assign halted = halted_q;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign halt_fire   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    valid_d    = valid_q;
    cycles_d   = cycles_q;
    wr_count_d = wr_count_q;
    halted_d   = halted_q;
    end_cond   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        cycles_d = sat_inc16(cycles_q);
        if (memwrite) begin
          wr_count_d = sat_inc8(wr_count_q);
          if (address == RESULT_ADDR) begin
            result_d = data_out;
            valid_d  = 1'b1;
          end
        end
        end_cond = (cycles_q == END_CYC) || halt_fire;
        // grading looks at the next-state result so an end-cycle write counts
        if (end_cond) begin
          halted_d = halt_fire;
          if (!valid_d) begin
            state_d = ST_TIMEOUT;
          end else if (result_d == EXPECT) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_d = state_q;
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      result_q   <= 8'h00;
      valid_q    <= 1'b0;
      cycles_q   <= 16'h0000;
      wr_count_q <= 8'h00;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      cycles_q   <= cycles_d;
      wr_count_q <= wr_count_d;
      halted_q   <= halted_d;
    end
  end

`ifndef MON_HALT_EN
  logic unused_halted;
  assign unused_halted = halted_q;
`endif

  assign state        = state_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign cycles       = cycles_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_bus_result_monitor.sv
// tb/tb_bus_result_monitor.sv - directed self-checking bench for bus_result_monitor
// Halt-detection vectors follow `define MON_HALT_EN.
module tb_bus_result_monitor;

  logic        ph2 = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        memwrite;
  logic        sync;
  logic [2:0]  state;
  logic        done, pass, fail;
  logic [7:0]  result;
  logic        result_valid;
  logic [15:0] cycles;
  logic [7:0]  wr_count;
`ifdef MON_HALT_EN
  logic        halted;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cur_cyc;

  int          n_wr;
  int          wr_cyc[8];
  logic [15:0] wr_addr[8];
  logic [7:0]  wr_data[8];
  int          sync_from, sync_to;

  bus_result_monitor dut (
    .ph2         (ph2),
    .reset       (reset),
    .address     (address),
    .data_out    (data_out),
    .memwrite    (memwrite),
    .sync        (sync),
    .state       (state),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .result      (result),
    .result_valid(result_valid),
    .cycles      (cycles),
    .wr_count    (wr_count)
`ifdef MON_HALT_EN
    ,
    .halted      (halted)
`endif
  );

  always #5 ph2 = ~ph2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic [7:0] res,
                            input logic rv, input logic [7:0] wrc, input logic [15:0] cyc);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".done"}, 32'(done), 32'(st >= 3'd2));
    check({tag, ".pass"}, 32'(pass), 32'(st == 3'd2));
    check({tag, ".fail"}, 32'(fail), 32'(st == 3'd3 || st == 3'd4));
    check({tag, ".result"}, 32'(result), 32'(res));
    check({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    check({tag, ".wr_count"}, 32'(wr_count), 32'(wrc));
    check({tag, ".cycles"}, 32'(cycles), 32'(cyc));
  endtask

  task automatic clear_sched();
    n_wr      = 0;
    sync_from = -1;
    sync_to   = -1;
  endtask

  task automatic add_wr(input int c, input logic [15:0] a, input logic [7:0] d);
    wr_cyc[n_wr]  = c;
    wr_addr[n_wr] = a;
    wr_data[n_wr] = d;
    n_wr++;
  endtask

  task automatic drive(input int c);
    memwrite = 1'b0;
    address  = 16'hxxxx;
    data_out = 8'hxx;
    sync     = 1'b0;
    if (c >= sync_from && c <= sync_to) begin
      sync    = 1'b1;
      address = 16'hF010;
    end
    for (int i = 0; i < n_wr; i++) begin
      if (wr_cyc[i] == c) begin
        memwrite = 1'b1;
        address  = wr_addr[i];
        data_out = wr_data[i];
      end
    end
  endtask

  // Leaves the DUT one edge past reset release (in RUN, cycles==0), sampled at negedge.
  task automatic start_run();
    @(negedge ph2);
    reset    = 1'b1;
    memwrite = 1'b0;
    sync     = 1'b0;
    repeat (5) @(posedge ph2);
    @(negedge ph2);
    check_outs("reset", 3'd0, 8'h00, 1'b0, 8'h00, 16'h0000);
    reset = 1'b0;
    drive(-1);
    @(posedge ph2);
    @(negedge ph2);
    cur_cyc = 0;
  endtask

  task automatic run_to(input int target);
    while (cur_cyc < target) begin
      drive(cur_cyc);
      @(posedge ph2);
      @(negedge ph2);
      cur_cyc++;
    end
    drive(-1);
  endtask

  initial begin
    reset    = 1'b1;
    address  = 16'h0000;
    data_out = 8'h00;
    memwrite = 1'b0;
    sync     = 1'b0;

    // PASS on a single correct write; grading only after the full window
    clear_sched();
    add_wr(10, 16'h0042, 8'hCF);
    start_run();
    check("t1.run_state", 32'(state), 32'd1);
    run_to(63);
    check_outs("t1.pre_end", 3'd1, 8'hCF, 1'b1, 8'h01, 16'd63);
    run_to(64);
    check_outs("t1.end", 3'd2, 8'hCF, 1'b1, 8'h01, 16'd64);
    add_wr(64, 16'h0042, 8'h00);
    add_wr(65, 16'h0100, 8'h55);
    run_to(70);
    check_outs("t1.sticky", 3'd2, 8'hCF, 1'b1, 8'h01, 16'd64);

    // last write wins
    clear_sched();
    add_wr(5, 16'h0042, 8'h12);
    add_wr(20, 16'h0042, 8'hCF);
    add_wr(40, 16'h0042, 8'h00);
    start_run();
    run_to(64);
    check_outs("t2.fail", 3'd3, 8'h00, 1'b0 | 1'b1, 8'h03, 16'd64);

    // no result write at all
    clear_sched();
    for (int i = 1; i <= 5; i++) add_wr(i, 16'h0100, 8'hA0 + 8'(i));
    start_run();
    run_to(64);
    check_outs("t3.timeout", 3'd4, 8'h00, 1'b0, 8'h05, 16'd64);

    // result written in the end cycle itself
    clear_sched();
    add_wr(63, 16'h0042, 8'hCF);
    start_run();
    run_to(63);
    check_outs("t4.pre_end", 3'd1, 8'h00, 1'b0, 8'h00, 16'd63);
    run_to(64);
    check_outs("t4.end", 3'd2, 8'hCF, 1'b1, 8'h01, 16'd64);

    // reset mid-run clears everything, then a clean run times out
    clear_sched();
    add_wr(10, 16'h0042, 8'hCF);
    start_run();
    run_to(30);
    check_outs("t5.mid", 3'd1, 8'hCF, 1'b1, 8'h01, 16'd30);
    clear_sched();
    start_run();
    run_to(64);
    check_outs("t5.timeout", 3'd4, 8'h00, 1'b0, 8'h00, 16'd64);

    // JMP-to-self halt: three fetches at F010 ending in cycle 20
    clear_sched();
    add_wr(5, 16'h0042, 8'hCF);
    sync_from = 18;
    sync_to   = 63;
    start_run();
    run_to(21);
`ifdef MON_HALT_EN
    check_outs("t6.halt", 3'd2, 8'hCF, 1'b1, 8'h01, 16'd21);
    check("t6.halted", 32'(halted), 32'd1);
`else
    check_outs("t6.no_halt", 3'd1, 8'hCF, 1'b1, 8'h01, 16'd21);
    run_to(64);
    check_outs("t6.end", 3'd2, 8'hCF, 1'b1, 8'h01, 16'd64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
